// File: rtl/riscv_rob_param_pkg.sv
// Shared instruction-info package for the reorder buffer.
// Holds the opcode-class encoding and its width. Widths derived from the
// ROB depth are kept local to the ROB itself.
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 4
`endif

package riscv_rob_param_pkg;

    localparam int INST_TYPE_W = `INST_TYPE_WIDTH;

    typedef enum logic [`INST_TYPE_WIDTH-1:0] {
        TYPE_ALU    = `INST_TYPE_WIDTH'(0),
        TYPE_LOAD   = `INST_TYPE_WIDTH'(1),
        TYPE_STORE  = `INST_TYPE_WIDTH'(2),
        TYPE_BRANCH = `INST_TYPE_WIDTH'(3),
        TYPE_JAL    = `INST_TYPE_WIDTH'(4),
        TYPE_JALR   = `INST_TYPE_WIDTH'(5)
    } inst_type_e;

endpackage

// File: rtl/riscv_rob_param_classify.sv
// Opcode-class decoder for one ROB commit slot.
// Ports:
//   inst_type  in   opcode class of the entry sitting in this slot
//   is_branch  out  conditional branch
//   is_store   out  store
//   is_jal     out  direct jump
//   is_jalr    out  indirect jump
module riscv_rob_classify
    import riscv_rob_param_pkg::*;
(
    input  logic [INST_TYPE_W-1:0] inst_type,
    output logic                   is_branch,
    output logic                   is_store,
    output logic                   is_jal,
    output logic                   is_jalr
);

    always_comb begin
        is_branch = 1'b0;
        is_store  = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        case (inst_type)
            TYPE_BRANCH: is_branch = 1'b1;
            TYPE_STORE:  is_store  = 1'b1;
            TYPE_JAL:    is_jal    = 1'b1;
            TYPE_JALR:   is_jalr   = 1'b1;
            default:     ;
        endcase
    end

endmodule

// File: rtl/riscv_rob_param.sv
// Parameterised reorder buffer with multi-port writeback, operand lookup
// with writeback bypass, in-order commit of up to two entries per cycle,
// branch resolution at the head and store release.
// Ports:
//   clk, rst (async, active-low), rdy (global enable), flush (external clear)
//   alloc_*   allocation handshake, entry payload and granted tag
//   wb_*      per-port writeback strobe, tag, value and resolved target
//   q_*       two operand lookups (tag in, ready/value out)
//   commit_*  per-slot register commit strobe, tag, rd and value
//   store_go  head store may perform its memory write
//   bht_*     branch-history update for the branch resolved at the head
//   redirect_* fetch redirect on misprediction
//   count     occupied entries
module riscv_rob_param
    import riscv_rob_param_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int DATA_W   = 32,
    parameter int WB_PORTS = 2,
    parameter int COMMIT_W = 2,
    localparam int TAG_W   = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         flush,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [DATA_W-1:0]            alloc_pc,
    input  logic [DATA_W-1:0]            alloc_jumppc,
    input  logic [INST_TYPE_W-1:0]       alloc_type,
    input  logic [4:0]                   alloc_dest,
    input  logic                         alloc_pred,
    output logic [TAG_W-1:0]             alloc_tag,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_value,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_jumppc,
    input  logic [2*TAG_W-1:0]           q_tag,
    output logic [1:0]                   q_ready,
    output logic [2*DATA_W-1:0]          q_value,
    output logic [COMMIT_W-1:0]          commit_valid,
    output logic [COMMIT_W*TAG_W-1:0]    commit_tag,
    output logic [COMMIT_W*5-1:0]        commit_rd,
    output logic [COMMIT_W*DATA_W-1:0]   commit_value,
    output logic                         store_go,
    output logic                         bht_upd,
    output logic                         bht_taken,
    output logic                         bht_hit,
    output logic [DATA_W-1:0]            bht_pc,
    output logic                         redirect_valid,
    output logic [DATA_W-1:0]            redirect_pc,
    output logic [TAG_W:0]               count
);

    logic [TAG_W:0]           head, tail;
    logic [DEPTH-1:0]         busy, ready;
    logic [DATA_W-1:0]        pc_mem  [DEPTH];
    logic [DATA_W-1:0]        jpc_mem [DEPTH];
    logic [DATA_W-1:0]        val_mem [DEPTH];
    logic [INST_TYPE_W-1:0]   type_mem[DEPTH];
    logic [4:0]               rd_mem  [DEPTH];
    logic [DEPTH-1:0]         pred_mem;

    logic                     full, alloc_fire, mispredict, clear_all, taken0;
    logic [1:0]               retire;
    logic [TAG_W-1:0]         slot_idx[2];
    logic [1:0]               s_br, s_st, s_jal, s_jalr, s_ok;

    // Extra pointer MSB separates full from empty when the low bits match.
    assign full        = (head[TAG_W] != tail[TAG_W]) &&
                         (head[TAG_W-1:0] == tail[TAG_W-1:0]);
    assign count       = tail - head;
    assign alloc_ready = !full;
    assign alloc_tag   = tail[TAG_W-1:0];
    assign alloc_fire  = alloc_valid && alloc_ready;

    assign slot_idx[0] = head[TAG_W-1:0];
    assign slot_idx[1] = head[TAG_W-1:0] + TAG_W'(1);

    for (genvar s = 0; s < 2; s++) begin : g_slot
        if (s < COMMIT_W) begin : g_cls
            riscv_rob_classify u_classify (
                .inst_type (type_mem[slot_idx[s]]),
                .is_branch (s_br[s]),
                .is_store  (s_st[s]),
                .is_jal    (s_jal[s]),
                .is_jalr   (s_jalr[s])
            );
        end else begin : g_none
            assign s_br[s]   = 1'b0;
            assign s_st[s]   = 1'b0;
            assign s_jal[s]  = 1'b0;
            assign s_jalr[s] = 1'b0;
        end
        assign s_ok[s] = busy[slot_idx[s]] && ready[slot_idx[s]];
    end

    // Commit decision, branch resolution and store release at the head.
    always_comb begin
        retire[0]  = rdy && s_ok[0];
        // Slot 1 never retires behind control flow or a store, so a redirect
        // or memory write always happens with the head alone in flight.
        retire[1]  = (COMMIT_W == 2) && retire[0] &&
                     !(s_br[0] || s_jal[0] || s_jalr[0] || s_st[0]) && s_ok[1] &&
                     !(s_br[1] || s_jal[1] || s_jalr[1] || s_st[1]);
        taken0     = s_br[0] ? val_mem[slot_idx[0]][0] : 1'b1;
        mispredict = retire[0] &&
                     ((s_br[0] && (val_mem[slot_idx[0]][0] ^ pred_mem[slot_idx[0]])) ||
                      s_jalr[0]);
        clear_all  = flush || mispredict;

        redirect_valid = mispredict;
        redirect_pc    = '0;
        if (mispredict)
            redirect_pc = taken0 ? jpc_mem[slot_idx[0]] : pc_mem[slot_idx[0]] + DATA_W'(4);

        bht_upd   = retire[0] && (s_br[0] || s_jalr[0]);
        bht_hit   = bht_upd && !mispredict;
        bht_taken = bht_upd && taken0;
        bht_pc    = bht_upd ? pc_mem[slot_idx[0]] : '0;

        store_go  = rdy && busy[slot_idx[0]] && !ready[slot_idx[0]] && s_st[0];

        commit_valid = '0;
        commit_tag   = '0;
        commit_rd    = '0;
        commit_value = '0;
        for (int s = 0; s < COMMIT_W; s++) begin
            // Branches and stores retire without a register write.
            if (retire[s] && !s_st[s] && !s_br[s]) begin
                commit_valid[s]                   = 1'b1;
                commit_tag[s*TAG_W +: TAG_W]      = slot_idx[s];
                commit_rd[s*5 +: 5]               = rd_mem[slot_idx[s]];
                commit_value[s*DATA_W +: DATA_W]  = val_mem[slot_idx[s]];
            end
        end
    end

    // Operand lookup; a same-cycle writeback wins over the stored value and
    // the highest-numbered matching port wins among writebacks.
    always_comb begin
        q_ready = '0;
        q_value = '0;
        for (int i = 0; i < 2; i++) begin
            if (ready[q_tag[i*TAG_W +: TAG_W]]) begin
                q_ready[i]                  = 1'b1;
                q_value[i*DATA_W +: DATA_W] = val_mem[q_tag[i*TAG_W +: TAG_W]];
            end
            for (int p = 0; p < WB_PORTS; p++) begin
                if (rdy && wb_valid[p] && busy[q_tag[i*TAG_W +: TAG_W]] &&
                    wb_tag[p*TAG_W +: TAG_W] == q_tag[i*TAG_W +: TAG_W]) begin
                    q_ready[i]                  = 1'b1;
                    q_value[i*DATA_W +: DATA_W] = wb_value[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Control state: pointers and per-entry busy/ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            busy  <= '0;
            ready <= '0;
        end else if (rdy) begin
            if (clear_all) begin
                head  <= '0;
                tail  <= '0;
                busy  <= '0;
                ready <= '0;
            end else begin
                if (alloc_fire) begin
                    busy[tail[TAG_W-1:0]]  <= 1'b1;
                    ready[tail[TAG_W-1:0]] <= 1'b0;
                    tail                   <= tail + (TAG_W+1)'(1);
                end
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (wb_valid[p] && busy[wb_tag[p*TAG_W +: TAG_W]])
                        ready[wb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
                end
                for (int s = 0; s < 2; s++) begin
                    if (retire[s]) begin
                        busy[slot_idx[s]]  <= 1'b0;
                        ready[slot_idx[s]] <= 1'b0;
                    end
                end
                head <= head + (TAG_W+1)'(retire[0]) + (TAG_W+1)'(retire[1]);
            end
        end
    end

    // Entry payload; validity is carried entirely by busy/ready.
    always_ff @(posedge clk) begin
        if (rdy && !clear_all) begin
            if (alloc_fire) begin
                pc_mem[tail[TAG_W-1:0]]   <= alloc_pc;
                jpc_mem[tail[TAG_W-1:0]]  <= alloc_jumppc;
                type_mem[tail[TAG_W-1:0]] <= alloc_type;
                rd_mem[tail[TAG_W-1:0]]   <= alloc_dest;
                pred_mem[tail[TAG_W-1:0]] <= alloc_pred;
            end
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && busy[wb_tag[p*TAG_W +: TAG_W]]) begin
                    val_mem[wb_tag[p*TAG_W +: TAG_W]] <= wb_value[p*DATA_W +: DATA_W];
                    jpc_mem[wb_tag[p*TAG_W +: TAG_W]] <= wb_jumppc[p*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_rob_param.sv
module tb_riscv_rob_param;
    import riscv_rob_param_pkg::*;

    localparam int DEPTH = 16, DATA_W = 32, WBP = 2, CW = 2, TW = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   rdy = 1'b1;
    logic                   flush = 1'b0;
    logic                   alloc_valid = 1'b0;
    logic                   alloc_ready;
    logic [DATA_W-1:0]      alloc_pc = '0, alloc_jumppc = '0;
    logic [INST_TYPE_W-1:0] alloc_type = '0;
    logic [4:0]             alloc_dest = '0;
    logic                   alloc_pred = 1'b0;
    logic [TW-1:0]          alloc_tag;
    logic [WBP-1:0]         wb_valid = '0;
    logic [WBP*TW-1:0]      wb_tag = '0;
    logic [WBP*DATA_W-1:0]  wb_value = '0, wb_jumppc = '0;
    logic [2*TW-1:0]        q_tag = '0;
    logic [1:0]             q_ready;
    logic [2*DATA_W-1:0]    q_value;
    logic [CW-1:0]          commit_valid;
    logic [CW*TW-1:0]       commit_tag;
    logic [CW*5-1:0]        commit_rd;
    logic [CW*DATA_W-1:0]   commit_value;
    logic                   store_go, bht_upd, bht_taken, bht_hit, redirect_valid;
    logic [DATA_W-1:0]      bht_pc, redirect_pc;
    logic [TW:0]            count;

    riscv_rob_param #(.DEPTH(DEPTH), .DATA_W(DATA_W), .WB_PORTS(WBP), .COMMIT_W(CW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_pc(alloc_pc), .alloc_jumppc(alloc_jumppc), .alloc_type(alloc_type),
        .alloc_dest(alloc_dest), .alloc_pred(alloc_pred), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_jumppc(wb_jumppc),
        .q_tag(q_tag), .q_ready(q_ready), .q_value(q_value),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
        .commit_value(commit_value), .store_go(store_go),
        .bht_upd(bht_upd), .bht_taken(bht_taken), .bht_hit(bht_hit), .bht_pc(bht_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0]     tag;
        logic [4:0]        rd;
        logic [DATA_W-1:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [TW:0] exp_tail = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_commit(input logic [TW-1:0] tag, input logic [4:0] rd,
                                 input logic [DATA_W-1:0] val);
        exp_t e;
        e.tag = tag; e.rd = rd; e.val = val;
        sb.push_back(e);
    endtask

    task automatic alloc(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] jpc,
                         input inst_type_e ty, input logic [4:0] rd, input logic pred);
        chk("alloc_ready", alloc_ready, 1);
        chk("alloc_tag", alloc_tag, exp_tail[TW-1:0]);
        alloc_valid = 1'b1; alloc_pc = pc; alloc_jumppc = jpc;
        alloc_type = ty; alloc_dest = rd; alloc_pred = pred;
        tick;
        alloc_valid = 1'b0;
        exp_tail++;
    endtask

    task automatic wb_set(input int port, input logic [TW-1:0] tag,
                          input logic [DATA_W-1:0] val, input logic [DATA_W-1:0] jpc);
        wb_valid[port] = 1'b1;
        wb_tag[port*TW +: TW] = tag;
        wb_value[port*DATA_W +: DATA_W] = val;
        wb_jumppc[port*DATA_W +: DATA_W] = jpc;
    endtask

    task automatic wb_one(input int port, input logic [TW-1:0] tag,
                          input logic [DATA_W-1:0] val, input logic [DATA_W-1:0] jpc);
        wb_set(port, tag, val, jpc);
        tick;
        wb_valid = '0;
        #1;
    endtask

    // Commit monitor: every register commit must match the next expected one.
    always @(negedge clk) begin
        if (rst) begin
            for (int s = 0; s < CW; s++) begin
                if (commit_valid[s]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_commit: slot %0d tag 0x%0h, required no commit",
                                 s, commit_tag[s*TW +: TW]);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("commit_tag", commit_tag[s*TW +: TW], mon_e.tag);
                        chk("commit_rd", commit_rd[s*5 +: 5], mon_e.rd);
                        chk("commit_value", commit_value[s*DATA_W +: DATA_W], mon_e.val);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_redirect", {redirect_valid, bht_upd, store_go}, 0);
        chk("rst_q_ready", q_ready, 0);
        rst = 1'b1;
        tick;

        // Fill to full, then one writeback frees exactly one slot
        for (int i = 0; i < 16; i++)
            alloc(32'(i * 4), '0, TYPE_ALU, 5'(i + 1), 1'b0);
        chk("full_count", count, 16);
        chk("full_alloc_ready", alloc_ready, 0);
        alloc_valid = 1'b1;
        tick;
        alloc_valid = 1'b0;
        chk("full_no_alloc", count, 16);
        expect_commit(4'd0, 5'd1, 32'h1000);
        wb_one(0, 4'd0, 32'h1000, '0);
        chk("no_bypass_alloc_ready", alloc_ready, 0);
        tick;
        chk("after_commit_count", count, 15);
        chk("after_commit_alloc_ready", alloc_ready, 1);
        for (int i = 1; i < 16; i++) begin
            expect_commit(4'(i), 5'(i + 1), 32'h1000 + 32'(i));
            wb_one(i % 2, 4'(i), 32'h1000 + 32'(i), '0);
        end
        tick; tick;
        chk("drain_count", count, 0);

        // Dual commit of two ready ALU entries
        alloc(32'h40, '0, TYPE_ALU, 5'd3, 1'b0);
        alloc(32'h44, '0, TYPE_ALU, 5'd4, 1'b0);
        expect_commit(4'd0, 5'd3, 32'hA0);
        expect_commit(4'd1, 5'd4, 32'hB0);
        wb_set(0, 4'd0, 32'hA0, '0);
        wb_set(1, 4'd1, 32'hB0, '0);
        tick;
        wb_valid = '0;
        #1;
        chk("dual_commit_valid", commit_valid, 2'b11);
        tick;
        chk("dual_count", count, 0);

        // Lookup bypass, port priority and ignored writeback to idle tag
        for (int i = 0; i < 4; i++)
            alloc(32'h80 + 32'(4 * i), '0, TYPE_ALU, 5'(10 + i), 1'b0);
        wb_set(1, 4'd5, 32'hDEAD, '0);
        q_tag = {4'd4, 4'd5};
        #1;
        chk("bypass_ready", q_ready[0], 1);
        chk("bypass_value", q_value[31:0], 32'hDEAD);
        chk("unwritten_ready", q_ready[1], 0);
        tick;
        wb_valid = '0;
        #1;
        chk("stored_ready", q_ready[0], 1);
        chk("stored_value", q_value[31:0], 32'hDEAD);
        wb_set(0, 4'd4, 32'h11, '0);
        wb_set(1, 4'd4, 32'h22, '0);
        #1;
        chk("port_prio_bypass", q_value[63:32], 32'h22);
        tick;
        wb_valid = '0;
        #1;
        chk("port_prio_stored", q_value[63:32], 32'h22);
        q_tag = {4'd9, 4'd0};
        wb_one(0, 4'd9, 32'h99, '0);
        chk("idle_tag_ignored", q_ready[1], 0);
        expect_commit(4'd2, 5'd10, 32'h2002);
        expect_commit(4'd3, 5'd11, 32'h3003);
        expect_commit(4'd4, 5'd12, 32'h22);
        expect_commit(4'd5, 5'd13, 32'hDEAD);
        wb_set(0, 4'd2, 32'h2002, '0);
        wb_set(1, 4'd3, 32'h3003, '0);
        tick;
        wb_valid = '0;
        tick; tick;
        chk("bypass_drain_count", count, 0);

        // Mispredicted BEQ flushes a younger entry
        alloc(32'h100, 32'h200, TYPE_BRANCH, 5'd0, 1'b1);
        alloc(32'h104, '0, TYPE_ALU, 5'd7, 1'b0);
        wb_one(0, 4'd6, 32'h0, 32'h200);
        chk("mp_redirect_valid", redirect_valid, 1);
        chk("mp_redirect_pc", redirect_pc, 32'h104);
        chk("mp_bht", {bht_upd, bht_hit, bht_taken}, 3'b100);
        chk("mp_bht_pc", bht_pc, 32'h100);
        tick;
        exp_tail = '0;
        chk("mp_count", count, 0);
        chk("mp_alloc_tag", alloc_tag, 0);

        // Correct BNE, JAL, JALR
        alloc(32'h200, 32'h300, TYPE_BRANCH, 5'd0, 1'b1);
        wb_one(1, 4'd0, 32'h1, 32'h300);
        chk("bne_redirect", redirect_valid, 0);
        chk("bne_bht", {bht_upd, bht_hit, bht_taken}, 3'b111);
        chk("bne_bht_pc", bht_pc, 32'h200);
        tick;
        chk("bne_count", count, 0);
        alloc(32'h400, 32'h500, TYPE_JAL, 5'd1, 1'b1);
        expect_commit(4'd1, 5'd1, 32'h404);
        wb_one(0, 4'd1, 32'h404, 32'h500);
        chk("jal_no_redirect", {redirect_valid, bht_upd}, 0);
        tick;
        alloc(32'h600, 32'h0, TYPE_JALR, 5'd5, 1'b1);
        expect_commit(4'd2, 5'd5, 32'h604);
        wb_one(0, 4'd2, 32'h604, 32'h7000);
        chk("jalr_redirect", redirect_valid, 1);
        chk("jalr_redirect_pc", redirect_pc, 32'h7000);
        chk("jalr_bht_hit", bht_hit, 0);
        tick;
        exp_tail = '0;
        chk("jalr_count", count, 0);

        // Store release
        alloc(32'h800, '0, TYPE_STORE, 5'd9, 1'b0);
        chk("store_go", store_go, 1);
        wb_one(0, 4'd0, 32'h0, '0);
        chk("store_go_done", store_go, 0);
        tick;
        chk("store_count", count, 0);

        // 40 alloc/commit pairs wrap tags and pointers
        for (int i = 0; i < 40; i++) begin
            logic [TW-1:0] t;
            t = exp_tail[TW-1:0];
            alloc(32'(i * 4), '0, TYPE_ALU, 5'((i % 31) + 1), 1'b0);
            chk("wrap_count_1", count, 1);
            expect_commit(t, 5'((i % 31) + 1), 32'(i + 100));
            wb_one(i % 2, t, 32'(i + 100), '0);
            tick;
            chk("wrap_count_0", count, 0);
        end

        // rdy=0 freezes allocation
        rdy = 1'b0;
        alloc_valid = 1'b1;
        tick;
        alloc_valid = 1'b0;
        rdy = 1'b1;
        chk("frozen_count", count, 0);
        chk("frozen_tag", alloc_tag, exp_tail[TW-1:0]);

        // Flush together with alloc and writeback
        for (int i = 0; i < 3; i++)
            alloc(32'h900 + 32'(4 * i), '0, TYPE_ALU, 5'd20, 1'b0);
        flush = 1'b1;
        alloc_valid = 1'b1;
        wb_set(0, 4'd9, 32'h77, '0);
        tick;
        flush = 1'b0;
        alloc_valid = 1'b0;
        wb_valid = '0;
        #1;
        exp_tail = '0;
        chk("flush_count", count, 0);
        chk("flush_tag", alloc_tag, 0);
        alloc(32'hA00, '0, TYPE_ALU, 5'd2, 1'b0);
        q_tag = {4'd9, 4'd0};
        #1;
        chk("flush_no_stale_ready", q_ready, 2'b00);
        tick; tick;
        chk("flush_realloc_count", count, 1);
        expect_commit(4'd0, 5'd2, 32'h55);
        wb_one(1, 4'd0, 32'h55, '0);
        tick;
        chk("flush_drain_count", count, 0);

        // Asynchronous reset mid-operation
        alloc(32'hB00, '0, TYPE_ALU, 5'd3, 1'b0);
        alloc(32'hB04, '0, TYPE_ALU, 5'd4, 1'b0);
        chk("pre_reset_count", count, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_alloc_ready", alloc_ready, 1);
        chk("async_rst_tag", alloc_tag, 0);
        tick;
        rst = 1'b1;
        exp_tail = '0;
        tick; tick;
        chk("post_rst_count", count, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_rob_param.md
RISCV_ROB_PARAM -- requirements
Module: riscv_rob_param

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, 4..64.
REQ-002 SHALL have parameter DATA_W, default 32, value/pc width.
REQ-003 SHALL have parameter WB_PORTS, default 2, independent writeback ports, 1..4.
REQ-004 SHALL have parameter COMMIT_W, default 2, maximum commits per cycle, 1 or 2.
REQ-005 SHALL have ports as follows; TAG_W = log2(DEPTH):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; 0 freezes all state.
- flush  in  1  external clear.
- alloc_valid, alloc_ready  in/out  1  allocation handshake.
- alloc_pc, alloc_jumppc  in  DATA_W  instruction pc / predicted target.
- alloc_type  in  `INST_TYPE_WIDTH  opcode class.
- alloc_dest  in  5  destination register.
- alloc_pred  in  1  predicted taken.
- alloc_tag  out  TAG_W  tag granted to the allocation.
- wb_valid  in  WB_PORTS  per-port writeback strobe.
- wb_tag  in  WB_PORTS*TAG_W  per-port tag.
- wb_value, wb_jumppc  in  WB_PORTS*DATA_W  result / resolved target.
- q_tag  in  2*TAG_W  operand lookup tags.
- q_ready  out  2  per-lookup ready flag.
- q_value  out  2*DATA_W  per-lookup value.
- commit_valid  out  COMMIT_W  per-slot commit strobe.
- commit_tag  out  COMMIT_W*TAG_W  per-slot tag.
- commit_rd  out  COMMIT_W*5  per-slot destination register.
- commit_value  out  COMMIT_W*DATA_W  per-slot value.
- store_go  out  1  head store may perform memory write.
- bht_upd, bht_taken, bht_hit  out  1  branch-history update, outcome, prediction correct.
- bht_pc  out  DATA_W  pc of the resolved branch.
- redirect_valid  out  1  misprediction redirect.
- redirect_pc  out  DATA_W  redirect target.
- count  out  TAG_W+1  occupied entries.

Function
REQ-006 SHALL keep head/tail pointers of TAG_W+1 bits; empty when equal; full when the low bits are equal and the MSBs differ.
REQ-007 SHALL assert alloc_ready = !full, derived only from registered count, with no same-cycle commit bypass.
REQ-008 SHALL drive alloc_tag = tail low bits; on alloc_valid&&alloc_ready, write the entry with ready=0, busy=1 and advance tail by 1.
REQ-009 SHALL apply wb_valid[p] only to busy entries; writeback to a non-busy tag is ignored; on equal tags, the highest port index wins.
REQ-010 SHALL make q_ready/q_value combinational: a same-cycle matching wb port takes priority, otherwise stored ready/value.
REQ-011 SHALL evaluate commit combinationally from registered head state; slot0 commits when the head is busy and ready.
REQ-012 SHALL commit slot1 (COMMIT_W=2) only if slot0 commits, neither slot is a branch or store, and slot1 is ready.
REQ-013 SHALL resolve a branch at slot0 as mispredicted when value[0]^pred or type==JALR; JAL is always correct.
REQ-014 SHALL, on misprediction: assert redirect_valid; set redirect_pc = jumppc if taken, else pc+4; assert bht_upd with bht_hit=0; commit rd only for JAL/JALR; clear all entries at that clock edge.
REQ-015 SHALL, on correct conditional-branch prediction, assert bht_upd with bht_hit=1, bht_taken=value[0] and bht_pc=pc.
REQ-016 SHALL assert store_go while the head is a non-ready busy store; the store retires, with commit_valid[0] and rd suppressed, once its writeback marks it ready.
REQ-017 SHALL advance head by the number of committed slots and compute count = tail-head.
REQ-018 SHALL give flush, external or internal redirect, priority over alloc, writeback and commit in the same cycle: head=tail=0, all busy/ready cleared, alloc ignored.
REQ-019 SHALL wrap pointers modulo 2*DEPTH with no loss of full/empty distinction.
REQ-020 SHALL gate every update with rdy; async reset overrides rdy.

Reset
REQ-021 SHALL, while rst=0, hold head=tail=0, every entry busy=0/ready=0, count=0, alloc_ready=1, all strobes and redirect/bht outputs 0, all data outputs 0.
REQ-022 SHALL, on reset assertion mid-operation, discard all in-flight entries immediately without waiting for a clock edge.

Structure
REQ-023 SHALL take opcode-class constants, `INST_TYPE_WIDTH, and JAL/JALR/branch/store codes from the shared info package; DEPTH-derived widths stay local.
REQ-024 SHALL instantiate one sub-module, riscv_rob_classify (type -> is_branch/is_store/is_jal/is_jalr), once per commit slot.

Verification
REQ-025 SHALL cover fill/drain: DEPTH=16, 16 allocs -> alloc_ready=0 at count=16; then one writeback -> one commit with count=15 and alloc_ready=1 next cycle.
REQ-026 SHALL cover dual commit: two ready ALU entries at head -> commit_valid=2'b11 in one cycle with head+=2.
REQ-027 SHALL cover mispredict: BEQ with pred=1, wb value=0, pc=0x100 -> redirect_pc=0x104, bht_hit=0, count=0 next cycle.
REQ-028 SHALL cover bypass: wb port1 tag 5 value 0xDEAD with q_tag0=5 in the same cycle -> q_ready[0]=1, q_value=0xDEAD.
REQ-029 SHALL cover wrap: 40 alloc/commit pairs at DEPTH=16 -> tags wrap 15->0 with no false full or empty.
REQ-030 SHALL cover simultaneous events: flush together with alloc_valid and wb_valid -> count=0 and no stale ready on the reallocated tag 0.
